// File: rtl/jesd204_rx_gearbox_pkg.sv
// Shared helpers for the JESD204 RX gearbox slice.
package jesd204_rx_gearbox_pkg;

    // Bit offset of byte idx within lane-major data where each lane holds lane_bytes bytes.
    function automatic int byte_lsb(input int lane, input int lane_bytes, input int idx);
        return (lane * lane_bytes + idx) * 8;
    endfunction

endpackage

// File: rtl/jesd204_rx_gearbox_fifo.sv
// Word FIFO for the RX gearbox; JESD204_RX_GEARBOX_OREG_EN adds a prefetch output register.
module jesd204_rx_gearbox_fifo
    import jesd204_rx_gearbox_pkg::*;
#(
    parameter int MEM_W  = 48,
    parameter int DEPTH  = 4,
    parameter int D_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [MEM_W-1:0] wr_data,
    input  logic             pop,
    output logic [MEM_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             full
);

    logic [MEM_W-1:0] mem [DEPTH];
    logic [D_LOG2:0]  wr_ptr_reg;
    logic [D_LOG2:0]  rd_ptr_reg;
    logic             mem_empty;
    logic             mem_full;
    logic             mem_rd;
    logic             mem_wr;

    assign mem_empty = (wr_ptr_reg == rd_ptr_reg);
    assign mem_full  = (wr_ptr_reg[D_LOG2] != rd_ptr_reg[D_LOG2]) &&
                       (wr_ptr_reg[D_LOG2-1:0] == rd_ptr_reg[D_LOG2-1:0]);

`ifdef JESD204_RX_GEARBOX_OREG_EN
    logic             oreg_valid_reg;
    logic [MEM_W-1:0] oreg_data_reg;

    // Refill the output register whenever it is empty or being drained this cycle.
    assign mem_rd = !mem_empty && (!oreg_valid_reg || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            oreg_valid_reg <= 1'b0;
            oreg_data_reg  <= '0;
        end else if (mem_rd) begin
            oreg_valid_reg <= 1'b1;
            oreg_data_reg  <= mem[rd_ptr_reg[D_LOG2-1:0]];
        end else if (pop) begin
            oreg_valid_reg <= 1'b0;
        end
    end

    assign rd_valid = oreg_valid_reg;
    assign rd_data  = oreg_data_reg;
`else
    assign mem_rd   = pop && !mem_empty;
    assign rd_valid = !mem_empty;
    assign rd_data  = mem_empty ? '0 : mem[rd_ptr_reg[D_LOG2-1:0]];
`endif

    // A full FIFO still takes a word when a slot frees up in the same cycle.
    assign full   = mem_full && !mem_rd;
    assign mem_wr = push && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (mem_wr)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (mem_rd)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr)
            mem[wr_ptr_reg[D_LOG2-1:0]] <= wr_data;
    end

endmodule

// File: rtl/jesd204_rx_gearbox_params.vh
// Derived constants shared by the gearbox top; included inside the module body after the parameters.
localparam int ACC_BYTES = OUT_DATA_PATH_WIDTH + IN_DATA_PATH_WIDTH - 1;
localparam int CNT_W     = $clog2(ACC_BYTES + 1);
localparam int D_LOG2    = $clog2(DEPTH);
localparam int MEM_W     = NUM_LANES * OUT_DATA_PATH_WIDTH * 8;

// File: rtl/jesd204_rx_gearbox.sv
// JESD204 RX gearbox: packs IN-byte lane beats into OUT-byte words and queues them.
// Optional JESD204_RX_GEARBOX_OREG_EN registers the FIFO output (one extra cycle of latency).
module jesd204_rx_gearbox
    import jesd204_rx_gearbox_pkg::*;
#(
    parameter int IN_DATA_PATH_WIDTH  = 4,
    parameter int OUT_DATA_PATH_WIDTH = 6,
    parameter int NUM_LANES           = 1,
    parameter int DEPTH               = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_LANES*IN_DATA_PATH_WIDTH*8-1:0]  in_data,
    input  logic                                     in_valid,
    input  logic                                     in_align,
    output logic [NUM_LANES*OUT_DATA_PATH_WIDTH*8-1:0] out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     overflow
);

`include "jesd204_rx_gearbox_params.vh"

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] cnt_next;
    logic             word_done;
    logic             fifo_full;
    logic             pop;
    logic             overflow_reg;
    logic [MEM_W-1:0] push_data;

    // An aligned beat restarts the packing period at byte 0.
    always_comb begin
        base      = in_align ? '0 : cnt_reg;
        total     = base + CNT_W'(IN_DATA_PATH_WIDTH);
        word_done = in_valid && (total >= CNT_W'(OUT_DATA_PATH_WIDTH));
        cnt_next  = word_done ? total - CNT_W'(OUT_DATA_PATH_WIDTH) : total;
    end

    assign pop = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (in_valid)
                cnt_reg <= cnt_next;
            if (word_done && fifo_full)
                overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [ACC_BYTES*8-1:0] acc_reg;
            logic [ACC_BYTES*8-1:0] merged;

            always_comb begin
                merged = in_align ? '0 : acc_reg;
                for (int k = 0; k < IN_DATA_PATH_WIDTH; k++)
                    merged[(int'(base) + k)*8 +: 8] = in_data[byte_lsb(gi, IN_DATA_PATH_WIDTH, k) +: 8];
            end

            always_ff @(posedge clk) begin
                if (reset)
                    acc_reg <= '0;
                else if (in_valid)
                    acc_reg <= word_done ? (merged >> (OUT_DATA_PATH_WIDTH*8)) : merged;
            end

            assign push_data[byte_lsb(gi, OUT_DATA_PATH_WIDTH, 0) +: OUT_DATA_PATH_WIDTH*8] =
                merged[OUT_DATA_PATH_WIDTH*8-1:0];
        end
    endgenerate

    jesd204_rx_gearbox_fifo #(
        .MEM_W  (MEM_W),
        .DEPTH  (DEPTH),
        .D_LOG2 (D_LOG2)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (word_done),
        .wr_data  (push_data),
        .pop      (pop),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .full     (fifo_full)
    );

endmodule
